// File: rtl/rc_pulse_capture_pkg.sv
// Shared constants and types for the RC pulse-width capture block.
package rc_pulse_capture_pkg;

  localparam int unsigned CLK_HZ     = 125_000_000;
  localparam int unsigned CLK_PER_US = CLK_HZ / 1_000_000;

  // Counter widths: 7-bit microsecond prescaler, 12-bit width counter,
  // 16-bit signal-loss timeout counter.
  localparam int unsigned PRESC_W = 7;
  localparam int unsigned WIDTH_W = 12;
  localparam int unsigned TO_W    = 16;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_MEASURE = 2'd1,
    ST_OVERRUN = 2'd2
  } state_e;

endpackage

// File: rtl/rc_pulse_capture_us_prescaler.sv
// Microsecond prescaler: counts 0..CYCLES-1 and emits a one-cycle tick
// while sitting on the terminal count. A synchronous clear restarts it at 0.
module us_prescaler #(
  parameter int unsigned CYCLES = rc_pulse_capture_pkg::CLK_PER_US
) (
  input  logic clk,
  input  logic reset_n,
  input  logic clear,
  output logic tick
);
  import rc_pulse_capture_pkg::*;

  logic [PRESC_W-1:0] cnt_q, cnt_d;

  assign tick = (cnt_q == PRESC_W'(CYCLES - 1));

  // Next count: restart on clear or wrap, otherwise advance.
  // NOTE: every signal assigned in always_comb gets a default first, so no path can infer a latch.
  always_comb begin
    cnt_d = cnt_q + PRESC_W'(1);
    if (clear || tick) cnt_d = '0;
  end

  // Count register.
  // NOTE: sequential state uses non-blocking (<=) so all flops update together at the edge.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) cnt_q <= '0;
    else          cnt_q <= cnt_d;
  end

endmodule

// File: rtl/rc_pulse_capture.sv
// RC receiver pulse capture: measures the high time of a servo/ESC pulse in
// whole microseconds, strobes valid/error, and flags loss of signal.
module rc_pulse_capture #(
  parameter int unsigned CLK_PER_US = rc_pulse_capture_pkg::CLK_PER_US,
  parameter int unsigned MIN_US     = 800,
  parameter int unsigned MAX_US     = 2200,
  parameter int unsigned TIMEOUT_US = 50000
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        pwm_in,
  output logic [11:0] width_us,
  output logic        valid,
  output logic        error,
  output logic        busy,
  output logic        signal_lost
);
  import rc_pulse_capture_pkg::*;

  // Input synchronizer and edge detect.
  logic sync1_q, pwm_s_q, pwm_d_q;
  logic rise, fall;

  // Synchronize pwm_in and keep one delayed copy for edge detection.
  // NOTE: these flops reset high so a line already high at reset release is not seen as a rising edge.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      sync1_q <= 1'b1;
      pwm_s_q <= 1'b1;
      pwm_d_q <= 1'b1;
    end else begin
      sync1_q <= pwm_in;
      pwm_s_q <= sync1_q;
      pwm_d_q <= pwm_s_q;
    end
  end

  assign rise = pwm_s_q & ~pwm_d_q;
  assign fall = ~pwm_s_q & pwm_d_q;

  // Measurement prescaler restarts on every rising edge; the timeout
  // prescaler free-runs.
  logic meas_tick, free_tick;

  us_prescaler #(.CYCLES(CLK_PER_US)) u_meas_presc (
    .clk     (clk),
    .reset_n (reset_n),
    .clear   (rise),
    .tick    (meas_tick)
  );

  us_prescaler #(.CYCLES(CLK_PER_US)) u_free_presc (
    .clk     (clk),
    .reset_n (reset_n),
    .clear   (1'b0),
    .tick    (free_tick)
  );

  // meas_cnt includes a tick landing in the current cycle, so on the fall
  // cycle it equals floor(N / CLK_PER_US) for N high cycles.
  logic [WIDTH_W-1:0] width_cnt_q, width_cnt_d, meas_cnt;
  state_e             state_q, state_d;
  logic [WIDTH_W-1:0] width_us_q, width_us_d;
  logic               valid_q, valid_d, error_q, error_d, busy_q, busy_d;
  logic [TO_W-1:0]    to_cnt_q, to_cnt_d;
  logic               signal_lost_q, signal_lost_d;

  assign meas_cnt = width_cnt_q + WIDTH_W'(meas_tick);

  // Width counter, FSM next state and strobes, timeout counter.
  always_comb begin
    width_cnt_d = width_cnt_q;
    if (rise)                         width_cnt_d = '0;
    else if (state_q == ST_MEASURE)   width_cnt_d = meas_cnt;

    state_d    = state_q;
    valid_d    = 1'b0;
    error_d    = 1'b0;
    width_us_d = width_us_q;
    case (state_q)
      ST_IDLE: begin
        if (rise) state_d = ST_MEASURE;
      end
      ST_MEASURE: begin
        if (fall) begin
          state_d = ST_IDLE;
          if (meas_cnt >= WIDTH_W'(MIN_US) && meas_cnt <= WIDTH_W'(MAX_US)) begin
            valid_d    = 1'b1;
            width_us_d = meas_cnt;
          end else begin
            error_d = 1'b1;
          end
        end else if (meas_cnt == WIDTH_W'(MAX_US + 1)) begin
          error_d = 1'b1;
          state_d = ST_OVERRUN;
        end
      end
      ST_OVERRUN: begin
        if (fall) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
    busy_d = (state_d != ST_IDLE);

    // A valid pulse always wins over a coinciding timeout expiry.
    to_cnt_d      = to_cnt_q;
    signal_lost_d = signal_lost_q;
    if (valid_d) begin
      to_cnt_d      = '0;
      signal_lost_d = 1'b0;
    end else begin
      if (free_tick && to_cnt_q != TO_W'(TIMEOUT_US)) to_cnt_d = to_cnt_q + TO_W'(1);
      if (to_cnt_d == TO_W'(TIMEOUT_US))              signal_lost_d = 1'b1;
    end
  end

  // FSM state, counters and registered outputs.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q       <= ST_IDLE;
      width_cnt_q   <= '0;
      width_us_q    <= '0;
      valid_q       <= 1'b0;
      error_q       <= 1'b0;
      busy_q        <= 1'b0;
      to_cnt_q      <= '0;
      signal_lost_q <= 1'b1;
    end else begin
      state_q       <= state_d;
      width_cnt_q   <= width_cnt_d;
      width_us_q    <= width_us_d;
      valid_q       <= valid_d;
      error_q       <= error_d;
      busy_q        <= busy_d;
      to_cnt_q      <= to_cnt_d;
      signal_lost_q <= signal_lost_d;
    end
  end

  assign width_us    = width_us_q;
  assign valid       = valid_q;
  assign error       = error_q;
  assign busy        = busy_q;
  assign signal_lost = signal_lost_q;

endmodule

// File: tb/tb_rc_pulse_capture.sv
// Self-checking bench for rc_pulse_capture with a behavioural width model.
module tb_rc_pulse_capture;

  localparam int C   = 5;
  localparam int MIN = 40;
  localparam int MAX = 100;
  localparam int TO  = 400;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic        pwm_in = 1'b0;
  logic [11:0] width_us;
  logic        valid, error, busy, signal_lost;

  int checks = 0;
  int errors = 0;
  int model_width = 0;

  // Strobe monitor.
  int n_valid = 0, n_error = 0, n_overlap = 0, n_glitch = 0;
  logic [11:0] prev_width = '0;

  always #4 clk = ~clk;

  rc_pulse_capture #(
    .CLK_PER_US (C),
    .MIN_US     (MIN),
    .MAX_US     (MAX),
    .TIMEOUT_US (TO)
  ) dut (
    .clk         (clk),
    .reset_n     (reset_n),
    .pwm_in      (pwm_in),
    .width_us    (width_us),
    .valid       (valid),
    .error       (error),
    .busy        (busy),
    .signal_lost (signal_lost)
  );

  always @(negedge clk) begin
    if (!reset_n) begin
      prev_width = width_us;
    end else begin
      if (valid) n_valid++;
      if (error) n_error++;
      if (valid && error) n_overlap++;
      if (width_us != prev_width && !valid) n_glitch++;
      prev_width = width_us;
    end
  end

  initial begin
    #2ms;
    $display("FAIL watchdog: simulation time limit reached, got no finish, required finish");
    $fatal(1, "watchdog");
  end

  // Reference model: a pulse of n high cycles measures floor(n / C) us.
  function automatic int model_us(input int n);
    return n / C;
  endfunction

  function automatic bit model_ok(input int n);
    return (model_us(n) >= MIN) && (model_us(n) <= MAX);
  endfunction

  task automatic settle();
    repeat (8) @(negedge clk);
    #1;
  endtask

  // Drive one pulse of n high cycles and compare strobes/width against the model.
  task automatic apply_pulse(input int n, input string name);
    int v0, e0, ev, ee;
    settle();
    v0 = n_valid;
    e0 = n_error;
    @(negedge clk);
    pwm_in = 1'b1;
    repeat (n) @(negedge clk);
    pwm_in = 1'b0;
    settle();
    ev = model_ok(n) ? 1 : 0;
    ee = model_ok(n) ? 0 : 1;
    if (model_ok(n)) model_width = model_us(n);
    checks++;
    if ((n_valid - v0) !== ev || (n_error - e0) !== ee) begin
      errors++;
      $display("FAIL %s n=%0d: valid/error count got %0d/%0d, required %0d/%0d",
               name, n, n_valid - v0, n_error - e0, ev, ee);
    end
    checks++;
    if (width_us !== 12'(model_width)) begin
      errors++;
      $display("FAIL %s n=%0d width_us: got %0d, required %0d", name, n, width_us, model_width);
    end
  endtask

  task automatic test_reset();
    reset_n = 1'b0;
    pwm_in  = 1'b0;
    repeat (5) @(negedge clk);
    checks++;
    if ({width_us, valid, error, busy, signal_lost} !== {12'd0, 1'b0, 1'b0, 1'b0, 1'b1}) begin
      errors++;
      $display("FAIL reset_values: got w=%0d v=%b e=%b b=%b sl=%b, required w=0 v=0 e=0 b=0 sl=1",
               width_us, valid, error, busy, signal_lost);
    end
    reset_n = 1'b1;
  endtask

  task automatic test_no_pulse();
    repeat (TO * C + 50) @(negedge clk);
    #1;
    checks++;
    if (signal_lost !== 1'b1 || width_us !== 12'd0 || busy !== 1'b0) begin
      errors++;
      $display("FAIL idle_line: got sl=%b w=%0d b=%b, required sl=1 w=0 b=0", signal_lost, width_us, busy);
    end
    checks++;
    if (n_valid !== 0 || n_error !== 0) begin
      errors++;
      $display("FAIL idle_strobes: got valid=%0d error=%0d, required 0/0", n_valid, n_error);
    end
  endtask

  task automatic test_nominal();
    int n, v0, k;
    bit seen;
    n  = 60 * C;
    v0 = n_valid;
    @(negedge clk);
    pwm_in = 1'b1;
    repeat (n / 2) @(negedge clk);
    checks++;
    if (busy !== 1'b1) begin
      errors++;
      $display("FAIL nominal_busy: got %b, required 1", busy);
    end
    repeat (n - n / 2) @(negedge clk);
    pwm_in = 1'b0;
    seen = 1'b0;
    k = 0;
    for (int i = 1; i <= 8 && !seen; i++) begin
      @(negedge clk);
      if (valid) begin
        seen = 1'b1;
        k = i;
      end
    end
    checks++;
    if (!seen || k > 4) begin
      errors++;
      $display("FAIL nominal_latency: got seen=%b after %0d edges, required seen=1 within 4", seen, k);
    end
    checks++;
    if (width_us !== 12'd60 || signal_lost !== 1'b0) begin
      errors++;
      $display("FAIL nominal_value: got w=%0d sl=%b, required w=60 sl=0", width_us, signal_lost);
    end
    model_width = 60;
    settle();
    checks++;
    if (n_valid - v0 !== 1 || busy !== 1'b0) begin
      errors++;
      $display("FAIL nominal_single: got valids=%0d busy=%b, required 1 and 0", n_valid - v0, busy);
    end
  endtask

  task automatic test_boundaries();
    apply_pulse(MIN * C, "min_exact");
    apply_pulse(MIN * C + C - 1, "min_plus");
    apply_pulse(MIN * C - 1, "min_short");
    apply_pulse(MAX * C + C - 1, "max_top");
    apply_pulse((MAX + 1) * C, "max_over");
  endtask

  task automatic test_overrun();
    int n, errs, vals, first_k, w0;
    n = 150 * C;
    errs = 0;
    vals = 0;
    first_k = -1;
    w0 = model_width;
    settle();
    @(negedge clk);
    pwm_in = 1'b1;
    for (int k = 1; k <= n; k++) begin
      @(negedge clk);
      if (error) begin
        errs++;
        if (first_k < 0) first_k = k;
      end
      if (valid) vals++;
    end
    checks++;
    if (busy !== 1'b1) begin
      errors++;
      $display("FAIL overrun_busy: got %b before fall, required 1", busy);
    end
    pwm_in = 1'b0;
    for (int k = 0; k < 8; k++) begin
      @(negedge clk);
      if (error) errs++;
      if (valid) vals++;
    end
    checks++;
    if (errs !== 1 || vals !== 0) begin
      errors++;
      $display("FAIL overrun_strobes: got error=%0d valid=%0d, required 1/0", errs, vals);
    end
    checks++;
    if (first_k !== (MAX + 1) * C + 3) begin
      errors++;
      $display("FAIL overrun_timing: error at edge %0d, required %0d", first_k, (MAX + 1) * C + 3);
    end
    checks++;
    if (busy !== 1'b0 || width_us !== 12'(w0)) begin
      errors++;
      $display("FAIL overrun_exit: got busy=%b w=%0d, required 0 and %0d", busy, width_us, w0);
    end
  endtask

  task automatic test_timeout();
    int k;
    bit seen;
    for (int f = 0; f < 3; f++) begin
      apply_pulse($urandom_range(MIN * C, MAX * C), "frame");
      repeat (400) @(negedge clk);
    end
    checks++;
    if (signal_lost !== 1'b0) begin
      errors++;
      $display("FAIL frames_signal: got sl=%b, required 0", signal_lost);
    end
    @(negedge clk);
    pwm_in = 1'b1;
    repeat (70 * C) @(negedge clk);
    pwm_in = 1'b0;
    seen = 1'b0;
    k = 0;
    for (int i = 1; i <= 8 && !seen; i++) begin
      @(negedge clk);
      if (valid) begin
        seen = 1'b1;
        k = i;
      end
    end
    model_width = 70;
    checks++;
    if (!seen) begin
      errors++;
      $display("FAIL timeout_last_valid: got no valid within 8 edges (k=%0d), required one", k);
    end
    repeat ((TO - 1) * C) @(negedge clk);
    checks++;
    if (signal_lost !== 1'b0) begin
      errors++;
      $display("FAIL timeout_early: got sl=%b before timeout, required 0", signal_lost);
    end
    repeat (C) @(negedge clk);
    checks++;
    if (signal_lost !== 1'b1) begin
      errors++;
      $display("FAIL timeout_expire: got sl=%b after timeout, required 1", signal_lost);
    end
    apply_pulse(50 * C, "recover");
    checks++;
    if (signal_lost !== 1'b0) begin
      errors++;
      $display("FAIL timeout_recover: got sl=%b, required 0", signal_lost);
    end
  endtask

  task automatic test_reset_mid_pulse();
    int v0, e0;
    settle();
    v0 = n_valid;
    e0 = n_error;
    @(negedge clk);
    pwm_in = 1'b1;
    repeat (50 * C) @(negedge clk);
    reset_n = 1'b0;
    repeat (4) @(negedge clk);
    checks++;
    if (width_us !== 12'd0 || signal_lost !== 1'b1 || busy !== 1'b0) begin
      errors++;
      $display("FAIL midreset_values: got w=%0d sl=%b b=%b, required 0/1/0", width_us, signal_lost, busy);
    end
    reset_n = 1'b1;
    model_width = 0;
    repeat (100) @(negedge clk);
    pwm_in = 1'b0;
    settle();
    checks++;
    if (n_valid !== v0 || n_error !== e0 || busy !== 1'b0) begin
      errors++;
      $display("FAIL midreset_discard: got valid=%0d error=%0d busy=%b, required 0/0/0",
               n_valid - v0, n_error - e0, busy);
    end
    apply_pulse(60 * C, "after_reset");
  endtask

  task automatic test_random();
    for (int i = 0; i < 16; i++) begin
      apply_pulse($urandom_range((MIN - 4) * C, (MAX + 4) * C), "random");
      repeat ($urandom_range(3, 40)) @(negedge clk);
    end
  endtask

  task automatic test_invariants();
    checks++;
    if (n_overlap !== 0) begin
      errors++;
      $display("FAIL strobe_overlap: got %0d cycles with valid&error, required 0", n_overlap);
    end
    checks++;
    if (n_glitch !== 0) begin
      errors++;
      $display("FAIL width_without_valid: got %0d changes, required 0", n_glitch);
    end
  endtask

  initial begin
    test_reset();
    test_no_pulse();
    test_nominal();
    test_boundaries();
    test_overrun();
    test_timeout();
    test_reset_mid_pulse();
    test_random();
    test_invariants();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
